loop_sequencer: RTL and testbench

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

---
 rtl/loop_sequencer.sv | 118 +++++++++++
 tb/tb_loop_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/loop_sequencer.sv
// Zero-overhead loop sequencer: an LCG instruction arms a hardware loop, the next
// issued instruction becomes the body, and the body is re-issued from the held IR.
module loop_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  input  logic        ex_ready,
  input  logic        cond_exit,
  output logic        issue_sel,
  output logic        fetch_stall,
  output logic        loop_active,
  output logic [8:0]  iter_left,
  output logic        loop_done
);

  localparam logic [6:0] LCG_OP = 7'b0000100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    LOOP = 2'b10
  } state_t;

  typedef struct packed {
    logic [8:0] cnt;
    logic [6:0] op;
  } instr_t;

  instr_t     ir;
  logic       is_lcg;
  state_t     state, state_nxt;
  logic [8:0] iter_nxt;
  logic       done_nxt;

  assign ir     = instr_t'(instr_in);
  assign is_lcg = instr_valid && (ir.op == LCG_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      iter_left <= '0;
      loop_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      iter_left <= iter_nxt;
      loop_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter_left;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // a zero-count LCG behaves as a NOP that still reports completion
        if (is_lcg) begin
          if (ir.cnt != 9'd0) begin
            state_nxt = ARM;
            iter_nxt  = ir.cnt;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      ARM: begin
        if (cond_exit) begin
          state_nxt = IDLE;
          iter_nxt  = '0;
          done_nxt  = 1'b1;
        end else if (is_lcg) begin
          if (ir.cnt != 9'd0) begin
            iter_nxt = ir.cnt;
          end else begin
            state_nxt = IDLE;
            iter_nxt  = '0;
            done_nxt  = 1'b1;
          end
        end else if (instr_valid && ex_ready) begin
          // body capture issues iteration 1 straight from fetch
          if (iter_left <= 9'd1) begin
            state_nxt = IDLE;
            iter_nxt  = '0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = LOOP;
            iter_nxt  = iter_left - 9'd1;
          end
        end
      end
      LOOP: begin
        if (cond_exit) begin
          state_nxt = IDLE;
          iter_nxt  = '0;
          done_nxt  = 1'b1;
        end else if (ex_ready) begin
          if (iter_left <= 9'd1) begin
            state_nxt = IDLE;
            iter_nxt  = '0;
            done_nxt  = 1'b1;
          end else begin
            iter_nxt = iter_left - 9'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        iter_nxt  = '0;
      end
    endcase
  end

  assign issue_sel   = (state == LOOP) && !cond_exit;
  assign fetch_stall = (state == LOOP);
  assign loop_active = (state == ARM) || (state == LOOP);

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer: hand-computed expectations checked with
// immediate assertions after each step.
module tb_loop_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        ex_ready;
  logic        cond_exit;
  logic        issue_sel;
  logic        fetch_stall;
  logic        loop_active;
  logic [8:0]  iter_left;
  logic        loop_done;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] BODY = 16'h0013;

  loop_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .ex_ready    (ex_ready),
    .cond_exit   (cond_exit),
    .issue_sel   (issue_sel),
    .fetch_stall (fetch_stall),
    .loop_active (loop_active),
    .iter_left   (iter_left),
    .loop_done   (loop_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lcg(input int n);
    logic [8:0] c;
    c = n[8:0];
    return {c, 7'b0000100};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // set inputs shortly after an edge and let combinational outputs settle
  task automatic drive(input logic v, input logic [15:0] ins, input logic rdy, input logic ce);
    instr_valid = v;
    instr_in    = ins;
    ex_ready    = rdy;
    cond_exit   = ce;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic isel, input logic fst,
                         input logic act, input int it, input logic dn);
    chk({tag, ".issue_sel"},   issue_sel,   isel);
    chk({tag, ".fetch_stall"}, fetch_stall, fst);
    chk({tag, ".loop_active"}, loop_active, act);
    chk({tag, ".iter_left"},   iter_left,   it);
    chk({tag, ".loop_done"},   loop_done,   dn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_it;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #10;
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // N=3: ARM issue + two LOOP re-issues
    drive(1'b1, lcg(3), 1'b1, 1'b0);
    tick();
    chk_all("n3.arm", 0, 0, 1, 3, 0);
    drive(1'b1, BODY, 1'b1, 1'b0);
    tick();
    drive(1'b0, BODY, 1'b1, 1'b0);
    chk_all("n3.loop1", 1, 1, 1, 2, 0);
    tick();
    chk_all("n3.loop2", 1, 1, 1, 1, 0);
    tick();
    chk_all("n3.end", 0, 0, 0, 0, 1);
    tick();
    chk("n3.done_once", loop_done, 0);

    // N=0: NOP with a single done pulse
    drive(1'b1, lcg(0), 1'b1, 1'b0);
    chk("n0.issue_sel", issue_sel, 0);
    tick();
    drive(1'b0, BODY, 1'b1, 1'b0);
    chk_all("n0.done", 0, 0, 0, 0, 1);
    tick();
    chk("n0.done_once", loop_done, 0);

    // cond_exit in IDLE is ignored; cond_exit in ARM aborts without capture
    drive(1'b1, BODY, 1'b1, 1'b1);
    tick();
    chk_all("idle_cexit", 0, 0, 0, 0, 0);
    drive(1'b1, lcg(3), 1'b1, 1'b0);
    tick();
    drive(1'b1, BODY, 1'b1, 1'b1);
    tick();
    drive(1'b0, BODY, 1'b1, 1'b0);
    chk_all("arm_cexit", 0, 0, 0, 0, 1);

    // N=1 completes in ARM
    drive(1'b1, lcg(1), 1'b1, 1'b0);
    tick();
    drive(1'b1, BODY, 1'b1, 1'b0);
    tick();
    drive(1'b0, BODY, 1'b1, 1'b0);
    chk_all("n1.end", 0, 0, 0, 0, 1);

    // N=5 with ex_ready toggling in LOOP
    drive(1'b1, lcg(5), 1'b1, 1'b0);
    tick();
    drive(1'b1, BODY, 1'b1, 1'b0);
    tick();
    chk("n5.enter", iter_left, 4);
    exp_it = 4;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, BODY, (i % 2 == 0), 1'b0);
      chk("n5.issue_sel", issue_sel, 1);
      chk("n5.fetch_stall", fetch_stall, 1);
      tick();
      if (i % 2 == 0) exp_it--;
      chk("n5.iter", iter_left, exp_it);
      chk("n5.active", loop_active, (exp_it != 0));
    end
    chk("n5.done", loop_done, 1);
    drive(1'b0, BODY, 1'b0, 1'b0);
    tick();
    chk("n5.done_once", loop_done, 0);

    // N=10 with early exit after the third LOOP issue
    drive(1'b1, lcg(10), 1'b1, 1'b0);
    tick();
    drive(1'b1, BODY, 1'b1, 1'b0);
    tick();
    drive(1'b0, BODY, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk("n10.iter_before", iter_left, 6);
    drive(1'b0, BODY, 1'b1, 1'b1);
    chk("n10.issue_sel_drop", issue_sel, 0);
    chk("n10.fetch_stall", fetch_stall, 1);
    tick();
    drive(1'b0, BODY, 1'b1, 1'b0);
    chk_all("n10.exit", 0, 0, 0, 0, 1);

    // N=511 with asynchronous reset mid-loop
    drive(1'b1, lcg(511), 1'b1, 1'b0);
    tick();
    chk("n511.arm", iter_left, 511);
    drive(1'b1, BODY, 1'b1, 1'b0);
    tick();
    drive(1'b0, BODY, 1'b1, 1'b0);
    repeat (310) tick();
    chk("n511.iter200", iter_left, 200);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("n511.async_rst", 0, 0, 0, 0, 0);
    tick();
    #2;
    rst_n = 1'b1;
    drive(1'b1, lcg(2), 1'b1, 1'b0);
    tick();
    chk_all("n2.arm", 0, 0, 1, 2, 0);
    drive(1'b1, BODY, 1'b1, 1'b0);
    tick();
    drive(1'b0, BODY, 1'b1, 1'b0);
    chk_all("n2.loop", 1, 1, 1, 1, 0);
    tick();
    chk_all("n2.end", 0, 0, 0, 0, 1);

    // reload in ARM: N=4 then N=7, then ARM reload with N=0 aborts
    drive(1'b1, lcg(4), 1'b1, 1'b0);
    tick();
    drive(1'b1, lcg(7), 1'b1, 1'b0);
    tick();
    chk_all("reload.arm", 0, 0, 1, 7, 0);
    drive(1'b1, BODY, 1'b1, 1'b0);
    tick();
    drive(1'b0, BODY, 1'b1, 1'b0);
    chk("reload.loop", iter_left, 6);
    repeat (5) tick();
    chk_all("reload.last", 1, 1, 1, 1, 0);
    tick();
    chk_all("reload.end", 0, 0, 0, 0, 1);
    drive(1'b1, lcg(4), 1'b1, 1'b0);
    tick();
    drive(1'b1, lcg(0), 1'b1, 1'b0);
    tick();
    drive(1'b0, BODY, 1'b1, 1'b0);
    chk_all("reload0", 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
